// File: rtl/int_top_buff_rx.sv
// int_top_buff_rx: UART rx (8N1, or 8E1 when BUFF_RX_PARITY_EN is defined) feeding a one-entry last-wins guess buffer; in: clk, nRst (async low), rx_serial, rec_ready; out: guess[7:0], err_LED
module int_top_buff_rx #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx_serial,
  input  logic       rec_ready,
  output logic       err_LED,
  output logic [7:0] guess
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] MSB = 3'(DATA_BITS - 1);
`ifdef BUFF_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;
`endif
  state_t state;
  logic rx_meta, rx_sync, pend_valid, frame_ok;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift, pending;
`ifdef BUFF_RX_PARITY_EN
  logic par_err;
  assign frame_ok = rx_sync && !par_err;
`else
  assign frame_ok = rx_sync;
`endif
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      pending <= '0;
      pend_valid <= 1'b0;
      guess <= '0;
      err_LED <= 1'b0;
`ifdef BUFF_RX_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
      if (pend_valid && rec_ready) begin
        guess <= pending;
        pend_valid <= 1'b0;
      end
      case (state)
        IDLE:
          if (!rx_sync) begin
            state <= START;
            cnt <= '0;
            bit_idx <= '0;
          end
        START:
          if (cnt == HALF) begin
            state <= rx_sync ? IDLE : DATA;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (cnt == LAST) begin
            cnt <= '0;
            shift[bit_idx] <= rx_sync;
            bit_idx <= bit_idx + 1'b1;
`ifdef BUFF_RX_PARITY_EN
            if (bit_idx == MSB) state <= PARITY;
`else
            if (bit_idx == MSB) state <= STOP;
`endif
          end else cnt <= cnt + 1'b1;
`ifdef BUFF_RX_PARITY_EN
        PARITY:
          if (cnt == LAST) begin
            cnt <= '0;
            par_err <= rx_sync ^ (^shift);
            state <= STOP;
          end else cnt <= cnt + 1'b1;
`endif
        STOP:
          if (cnt == LAST) begin
            cnt <= '0;
            state <= CLEANUP;
            if (frame_ok) begin
              pending <= shift;
              pend_valid <= 1'b1;
              err_LED <= 1'b0;
            end else err_LED <= 1'b1;
          end else cnt <= cnt + 1'b1;
        CLEANUP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_int_top_buff_rx.sv
// tb_int_top_buff_rx: randomized self-checking bench for int_top_buff_rx against a frame-level buffer model
module tb_int_top_buff_rx;
  localparam int CPB = 40;
  logic tb_clk = 1'b0;
  logic nRst = 1'b0;
  logic rx_serial = 1'b1;
  logic rec_ready = 1'b0;
  logic err_LED;
  logic [7:0] guess;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] m_guess = '0;
  logic [7:0] m_pend = '0;
  logic m_pv = 1'b0;
  logic m_err = 1'b0;

  always #5 tb_clk = ~tb_clk;

  int_top_buff_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk(tb_clk),
    .nRst(nRst),
    .rx_serial(rx_serial),
    .rec_ready(rec_ready),
    .err_LED(err_LED),
    .guess(guess)
  );

  task automatic set_ready(input logic r);
    rec_ready = r;
    if (r && m_pv) begin
      m_guess = m_pend;
      m_pv = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop_ok);
    rx_serial = 1'b0;
    repeat (CPB) @(negedge tb_clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (CPB) @(negedge tb_clk);
    end
`ifdef BUFF_RX_PARITY_EN
    rx_serial = ^b;
    repeat (CPB) @(negedge tb_clk);
`endif
    rx_serial = stop_ok;
    repeat (CPB) @(negedge tb_clk);
    rx_serial = 1'b1;
    repeat (CPB) @(negedge tb_clk);
    if (stop_ok) begin
      m_pend = b;
      m_pv = 1'b1;
      m_err = 1'b0;
    end else m_err = 1'b1;
    if (rec_ready && m_pv) begin
      m_guess = m_pend;
      m_pv = 1'b0;
    end
  endtask

  task automatic test_reset;
    nRst = 1'b0;
    repeat (2) @(negedge tb_clk);
    vectors += 2;
    if (guess !== 8'h00) begin miscompares++; $display("FAIL reset_guess got %h want 00", guess); end
    if (err_LED !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_LED); end
    nRst = 1'b1;
    repeat (20) @(negedge tb_clk);
    vectors += 2;
    if (guess !== 8'h00) begin miscompares++; $display("FAIL idle_guess got %h want 00", guess); end
    if (err_LED !== 1'b0) begin miscompares++; $display("FAIL idle_err got %b want 0", err_LED); end
  endtask

  task automatic test_good_frame;
    set_ready(1'b1);
    send(8'h41, 1'b1);
    vectors += 2;
    if (guess !== 8'h41) begin miscompares++; $display("FAIL good_guess got %h want 41", guess); end
    if (err_LED !== 1'b0) begin miscompares++; $display("FAIL good_err got %b want 0", err_LED); end
  endtask

  task automatic test_backpressure;
    set_ready(1'b0);
    send(8'h42, 1'b1);
    vectors++;
    if (guess !== 8'h41) begin miscompares++; $display("FAIL bp_hold got %h want 41", guess); end
    set_ready(1'b1);
    @(negedge tb_clk);
    vectors++;
    if (guess !== 8'h42) begin miscompares++; $display("FAIL bp_release got %h want 42", guess); end
  endtask

  task automatic test_overwrite;
    set_ready(1'b0);
    send(8'h43, 1'b1);
    send(8'h44, 1'b1);
    vectors++;
    if (guess !== 8'h42) begin miscompares++; $display("FAIL ow_hold got %h want 42", guess); end
    set_ready(1'b1);
    @(negedge tb_clk);
    vectors++;
    if (guess !== 8'h44) begin miscompares++; $display("FAIL ow_last_wins got %h want 44", guess); end
  endtask

  task automatic test_framing_error;
    send(8'h45, 1'b0);
    vectors += 2;
    if (err_LED !== 1'b1) begin miscompares++; $display("FAIL ferr_set got %b want 1", err_LED); end
    if (guess !== 8'h44) begin miscompares++; $display("FAIL ferr_guess got %h want 44", guess); end
    send(8'h46, 1'b1);
    vectors += 2;
    if (err_LED !== 1'b0) begin miscompares++; $display("FAIL ferr_clear got %b want 0", err_LED); end
    if (guess !== 8'h46) begin miscompares++; $display("FAIL ferr_next got %h want 46", guess); end
  endtask

  task automatic test_glitch;
    rx_serial = 1'b0;
    repeat (CPB / 4) @(negedge tb_clk);
    rx_serial = 1'b1;
    repeat (12 * CPB) @(negedge tb_clk);
    vectors += 2;
    if (err_LED !== 1'b0) begin miscompares++; $display("FAIL glitch_err got %b want 0", err_LED); end
    if (guess !== 8'h46) begin miscompares++; $display("FAIL glitch_guess got %h want 46", guess); end
  endtask

  task automatic test_mid_reset;
    logic [7:0] partial;
    partial = 8'h5A;
    rx_serial = 1'b0;
    repeat (CPB) @(negedge tb_clk);
    for (int i = 0; i < 3; i++) begin
      rx_serial = partial[i];
      repeat (CPB) @(negedge tb_clk);
    end
    nRst = 1'b0;
    #1;
    vectors += 2;
    if (guess !== 8'h00) begin miscompares++; $display("FAIL mrst_guess got %h want 00", guess); end
    if (err_LED !== 1'b0) begin miscompares++; $display("FAIL mrst_err got %b want 0", err_LED); end
    m_guess = '0;
    m_pend = '0;
    m_pv = 1'b0;
    m_err = 1'b0;
    rx_serial = 1'b1;
    repeat (2) @(negedge tb_clk);
    nRst = 1'b1;
    repeat (CPB) @(negedge tb_clk);
    set_ready(1'b1);
    send(8'h47, 1'b1);
    vectors += 2;
    if (guess !== 8'h47) begin miscompares++; $display("FAIL mrst_next got %h want 47", guess); end
    if (err_LED !== 1'b0) begin miscompares++; $display("FAIL mrst_next_err got %b want 0", err_LED); end
  endtask

  task automatic test_random;
    logic [7:0] b;
    logic ok;
    for (int n = 0; n < 24; n++) begin
      set_ready(1'($urandom_range(0, 1)));
      b = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send(b, ok);
      vectors += 2;
      if (guess !== m_guess) begin miscompares++; $display("FAIL rand%0d_guess got %h want %h", n, guess, m_guess); end
      if (err_LED !== m_err) begin miscompares++; $display("FAIL rand%0d_err got %b want %b", n, err_LED, m_err); end
    end
    set_ready(1'b1);
    @(negedge tb_clk);
    vectors++;
    if (guess !== m_guess) begin miscompares++; $display("FAIL rand_drain got %h want %h", guess, m_guess); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_backpressure();
    test_overwrite();
    test_framing_error();
    test_glitch();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
